// File: rtl/axi_decerr_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_decerr_slave_pkg
//  Description : Shared constants and FSM state types for the AXI4
//                decode-error responder on the crossbar's default port.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_decerr_slave_pkg;

  // AXI response code for a decode error
  localparam logic [1:0]  AxiRespDecErr = 2'b11;

  // Recognisable pattern returned on every read beat
  localparam logic [63:0] DecErrData    = 64'hDEAD_BEEF_BADC_AB1E;

  // Write channel: take AW, drain the W burst, then answer with one B
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } err_wr_state_t;

  // Read channel: take AR, then stream ARLEN+1 error beats
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } err_rd_state_t;

endpackage : axi_decerr_slave_pkg
`default_nettype wire

// File: rtl/axi_decerr_rd_ch.sv
`default_nettype none
// ============================================================================
//  Module      : axi_decerr_rd_ch
//  Description : Read half of the decode-error responder. Accepts one AR at a
//                time and returns ARLEN+1 beats, flagging the final one.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_decerr_rd_ch
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [ID_WIDTH-1:0] ar_id_i,
  input  logic [7:0]          ar_len_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic                r_last_o,
  output logic                ar_hs_o
);

  err_rd_state_t       r_state;
  logic                r_ar_ready;
  logic                r_valid;
  logic                r_last;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;

  logic                w_ar_hs;
  logic                w_r_hs;

  assign w_ar_hs = ar_valid_i & r_ar_ready;
  assign w_r_hs  = r_valid & r_ready_i;

  // Read FSM; r_last is precomputed so it is high exactly when r_cnt == r_len.
  // The 8-bit counter stops at the last beat, so len=255 never wraps it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      r_ar_ready <= 1'b1;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_id       <= '0;
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_state    <= R_DATA;
            r_ar_ready <= 1'b0;
            r_valid    <= 1'b1;
            r_id       <= ar_id_i;
            r_len      <= ar_len_i;
            r_cnt      <= 8'd0;
            r_last     <= (ar_len_i == 8'd0);
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_last) begin
              r_state    <= R_IDLE;
              r_ar_ready <= 1'b1;
              r_valid    <= 1'b0;
              r_last     <= 1'b0;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_last <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: begin
          r_state    <= R_IDLE;
          r_ar_ready <= 1'b1;
          r_valid    <= 1'b0;
          r_last     <= 1'b0;
        end
      endcase
    end
  end

  assign ar_ready_o = r_ar_ready;
  assign r_valid_o  = r_valid;
  assign r_last_o   = r_last;
  assign r_id_o     = r_id;
  assign ar_hs_o    = w_ar_hs;

endmodule : axi_decerr_rd_ch
`default_nettype wire

// File: rtl/axi_decerr_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_decerr_slave
//  Description : AXI4 default-port responder. Completes every access with
//                DECERR (full write drain + one B, ARLEN+1 read beats) and
//                keeps a saturating error count plus the last bad address.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_decerr_slave
  import axi_decerr_slave_pkg::*;
#(
  parameter int unsigned           ID_WIDTH   = 5,
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           CNT_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(DecErrData)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // AW
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  // W (data and strobes are discarded, so not brought in)
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  // B
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  // AR
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  // R
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  // Debug log
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_pulse_o
);

  err_wr_state_t         r_wr_state;
  logic                  r_aw_ready;
  logic                  r_w_ready;
  logic                  r_b_valid;
  logic [ID_WIDTH-1:0]   r_b_id;

  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_pulse;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic [CNT_WIDTH:0]    w_cnt_sum;
  logic [CNT_WIDTH-1:0]  w_cnt_next;

  assign w_aw_hs = aw_valid_i & r_aw_ready;
  assign w_w_hs  = w_valid_i & r_w_ready;

  // Write FSM: one outstanding write; W is stalled until AW has been taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_state <= W_IDLE;
      r_aw_ready <= 1'b1;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wr_state <= W_DATA;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b1;
            r_b_id     <= aw_id_i;
          end
        end
        W_DATA: begin
          if (w_w_hs && w_last_i) begin
            r_wr_state <= W_RESP;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            r_wr_state <= W_IDLE;
            r_b_valid  <= 1'b0;
            r_aw_ready <= 1'b1;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
          r_aw_ready <= 1'b1;
          r_w_ready  <= 1'b0;
          r_b_valid  <= 1'b0;
        end
      endcase
    end
  end

  axi_decerr_rd_ch #(
    .ID_WIDTH (ID_WIDTH)
  ) u_rd_ch (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_last_o   (r_last_o),
    .ar_hs_o    (w_ar_hs)
  );

  // One extra bit catches the carry; 2^N-1 + 2 always fits in N+1 bits
  assign w_cnt_sum  = {1'b0, r_err_cnt}
                    + (CNT_WIDTH+1)'(w_aw_hs)
                    + (CNT_WIDTH+1)'(w_ar_hs);
  assign w_cnt_next = w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                           : w_cnt_sum[CNT_WIDTH-1:0];

  // Error log: saturating count, last address (AW wins a tie), acceptance pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt   <= '0;
      r_err_addr  <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_cnt   <= w_cnt_next;
      r_err_pulse <= w_aw_hs | w_ar_hs;
      if (w_aw_hs) begin
        r_err_addr <= aw_addr_i;
      end else if (w_ar_hs) begin
        r_err_addr <= ar_addr_i;
      end
    end
  end

  assign aw_ready_o  = r_aw_ready;
  assign w_ready_o   = r_w_ready;
  assign b_valid_o   = r_b_valid;
  assign b_id_o      = r_b_id;
  assign b_resp_o    = AxiRespDecErr;
  assign r_data_o    = ERR_DATA;
  assign r_resp_o    = AxiRespDecErr;
  assign err_count_o = r_err_cnt;
  assign err_addr_o  = r_err_addr;
  assign err_pulse_o = r_err_pulse;

endmodule : axi_decerr_slave
`default_nettype wire

// File: tb/tb_axi_decerr_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_decerr_slave
//  Description : Self-checking bench for axi_decerr_slave (default widths and
//                a 2-bit counter instance for saturation).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_decerr_slave;

  localparam logic [63:0] c_err_data = 64'hDEAD_BEEF_BADC_AB1E;

  logic        clk = 1'b0;
  logic        rst_n;

  // main instance
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [4:0]  aw_id, b_id, ar_id, r_id;
  logic [63:0] aw_addr, ar_addr, r_data, err_addr;
  logic [1:0]  b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last, err_pulse;
  logic [7:0]  ar_len;
  logic [31:0] err_count;

  // 2-bit counter instance
  logic        aw2_valid, aw2_ready, w2_valid, w2_ready, w2_last, b2_valid, b2_ready;
  logic [4:0]  aw2_id, b2_id, ar2_id, r2_id;
  logic [63:0] aw2_addr, ar2_addr, r2_data, err2_addr;
  logic [1:0]  b2_resp, r2_resp;
  logic        ar2_valid, ar2_ready, r2_valid, r2_ready, r2_last, err2_pulse;
  logic [7:0]  ar2_len;
  logic [1:0]  err2_count;

  int          total = 0;
  int          bad   = 0;

  // reference model of the error log
  longint      exp_cnt;
  logic [63:0] exp_addr;

  always #5 clk = ~clk;

  axi_decerr_slave dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .err_count_o(err_count), .err_addr_o(err_addr), .err_pulse_o(err_pulse)
  );

  axi_decerr_slave #(.CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw2_valid), .aw_ready_o(aw2_ready), .aw_id_i(aw2_id), .aw_addr_i(aw2_addr),
    .w_valid_i(w2_valid), .w_ready_o(w2_ready), .w_last_i(w2_last),
    .b_valid_o(b2_valid), .b_ready_i(b2_ready), .b_id_o(b2_id), .b_resp_o(b2_resp),
    .ar_valid_i(ar2_valid), .ar_ready_o(ar2_ready), .ar_id_i(ar2_id), .ar_addr_i(ar2_addr),
    .ar_len_i(ar2_len),
    .r_valid_o(r2_valid), .r_ready_i(r2_ready), .r_id_o(r2_id), .r_data_o(r2_data),
    .r_resp_o(r2_resp), .r_last_o(r2_last),
    .err_count_o(err2_count), .err_addr_o(err2_addr), .err_pulse_o(err2_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input logic pulse);
    check({tag, "_cnt"},   err_count, exp_cnt);
    check({tag, "_addr"},  err_addr,  exp_addr);
    check({tag, "_pulse"}, err_pulse, pulse);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {aw_ready, ar_ready}, 2'b11);
    check({tag, "_valid"}, {w_ready, b_valid, r_valid, r_last, err_pulse}, 5'b0);
    check({tag, "_ids"},   {b_id, r_id}, 10'd0);
    check({tag, "_cnt"},   err_count, 0);
    check({tag, "_addr"},  err_addr, 0);
  endtask

  // one write transaction; wrand inserts random W bubbles
  task automatic do_write(input logic [4:0] id, input logic [63:0] addr,
                          input int nbeats, input int bdelay, input bit wrand);
    int accepted;
    int cyc;
    bit hs;
    aw_valid = 1'b1; aw_id = id; aw_addr = addr;
    w_valid  = 1'b1; w_last = 1'b0;
    check("w_stall_before_aw", w_ready, 1'b0);
    cyc = 0;
    while (!aw_ready && cyc < 50) begin tick(); cyc++; end
    check("aw_ready_idle", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    exp_cnt++; exp_addr = addr;
    check_log("aw_log", 1'b1);
    check("aw_ready_busy", {aw_ready, w_ready}, 2'b01);
    accepted = 0; cyc = 0;
    while (accepted < nbeats && cyc < 200) begin
      w_valid = wrand ? ($urandom_range(0, 2) != 0) : 1'b1;
      w_last  = (accepted == nbeats - 1);
      hs      = w_valid & w_ready;
      tick();
      if (hs) accepted++;
      cyc++;
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("w_beats", accepted, nbeats);
    check("b_after_last", {w_ready, b_valid, b_id, b_resp}, {1'b0, 1'b1, id, 2'b11});
    for (int i = 0; i < bdelay; i++) tick();
    check("b_hold", b_valid, 1'b1);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("b_done", {b_valid, aw_ready, err_pulse}, 3'b010);
  endtask

  // one read transaction; mode 0: ready always, 1: toggle, 2: random
  task automatic do_read(input logic [4:0] id, input logic [63:0] addr,
                         input int len, input int mode);
    int beats, lasts, drops, cyc;
    bit last_ok, data_ok, rr;
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
    check("ar_ready_idle", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    exp_cnt++; exp_addr = addr;
    check_log("ar_log", 1'b1);
    check("ar_ready_busy", ar_ready, 1'b0);
    beats = 0; lasts = 0; drops = 0; cyc = 0; last_ok = 1'b1; data_ok = 1'b1;
    while (beats < len + 1 && cyc < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      r_ready = rr;
      if (!r_valid) drops++;
      if (rr && r_valid) begin
        beats++;
        if (r_last !== (beats == len + 1)) last_ok = 1'b0;
        if (r_last) lasts++;
        if (r_data !== c_err_data || r_resp !== 2'b11 || r_id !== id) data_ok = 1'b0;
      end
      tick();
      cyc++;
    end
    r_ready = 1'b0;
    check("r_beats", beats, len + 1);
    check("r_last_count", lasts, 1);
    check("r_valid_drops", drops, 0);
    check("r_last_pos", last_ok, 1'b1);
    check("r_payload", data_ok, 1'b1);
    check("r_done", {r_valid, ar_ready}, 2'b01);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; w_valid = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; r_ready = 0;
    aw2_valid = 0; aw2_id = 0; aw2_addr = 0; w2_valid = 0; w2_last = 0; b2_ready = 0;
    ar2_valid = 0; ar2_id = 0; ar2_addr = 0; ar2_len = 0; r2_ready = 0;
    exp_cnt = 0; exp_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("dut2_rst_ctl",
          {aw2_ready, w2_ready, b2_valid, b2_id, b2_resp, ar2_ready, r2_valid, r2_id,
           r2_resp, r2_last, err2_pulse, err2_count},
          {1'b1, 1'b0, 1'b0, 5'd0, 2'b11, 1'b1, 1'b0, 5'd0, 2'b11, 1'b0, 1'b0, 2'd0});
    check("dut2_rst_data", r2_data, c_err_data);
    check("dut2_rst_addr", err2_addr, 64'd0);
    rst_n = 1'b1;
    tick();

    // saturation on a 2-bit counter: 1,2,3,3,3
    r2_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ar2_valid = 1'b1; ar2_id = 5'(k); ar2_addr = 64'(k);
      tick();
      ar2_valid = 1'b0;
      check("sat_count", err2_count, (k + 1 < 3) ? k + 1 : 3);
      tick();
    end
    r2_ready = 1'b0;

    // directed write and reads
    do_write(5'd5, 64'h5000_0000, 4, 0, 1'b0);
    do_read(5'd3, 64'h6000_0000, 0, 0);
    do_read(5'd9, 64'h7000_0040, 255, 1);

    // simultaneous AW + AR
    aw_valid = 1'b1; aw_id = 5'd7; aw_addr = 64'hA;
    ar_valid = 1'b1; ar_id = 5'd9; ar_addr = 64'hB; ar_len = 8'd2;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    exp_cnt += 2; exp_addr = 64'hA;
    check_log("dual", 1'b1);
    check("dual_r_last0", {r_valid, r_last}, 2'b10);
    w_valid = 1'b1; w_last = 1'b1; r_ready = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    check("dual_pulse_end", err_pulse, 1'b0);
    check("dual_b", {b_valid, b_id, b_resp, r_valid, r_last}, {1'b1, 5'd7, 2'b11, 1'b1, 1'b0});
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("dual_b_done", {b_valid, aw_ready, r_valid, r_last, r_id}, {1'b0, 1'b1, 1'b1, 1'b1, 5'd9});
    tick();
    r_ready = 1'b0;
    check("dual_r_done", {r_valid, ar_ready}, 2'b01);

    // reset in the middle of a write burst and a read burst
    aw_valid = 1'b1; aw_id = 5'd12; aw_addr = 64'hC000;
    tick();
    aw_valid = 1'b0; w_valid = 1'b1; w_last = 1'b0;
    tick();
    w_valid = 1'b0;
    ar_valid = 1'b1; ar_id = 5'd4; ar_addr = 64'hD000; ar_len = 8'd7;
    tick();
    ar_valid = 1'b0; r_ready = 1'b1;
    tick(); tick();
    r_ready = 1'b0;
    check("mid_state", {w_ready, r_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick(); tick();
    rst_n = 1'b1;
    exp_cnt = 0; exp_addr = 0;
    stray = 0;
    b_ready = 1'b1; r_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b_valid || r_valid || w_ready) stray++;
      tick();
    end
    b_ready = 1'b0; r_ready = 1'b0;
    check("no_stray_after_rst", stray, 0);
    do_write(5'd1, 64'h1234, 2, 1, 1'b0);
    do_read(5'd2, 64'h5678, 7, 0);

    // randomized transactions
    for (int i = 0; i < 6; i++) begin
      do_write(5'($urandom), {$urandom, $urandom}, $urandom_range(1, 8),
               $urandom_range(0, 3), 1'b1);
      do_read(5'($urandom), {$urandom, $urandom}, $urandom_range(0, 15), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule : tb_axi_decerr_slave
`default_nettype wire

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
AXI4 error responder on the crossbar's default (unmapped) port. It is hit by any access outside DRAM/GPIO/Ethernet/SPI/Timer/UART/PLIC/CLINT/ROM/Debug.
- Completes every transaction protocol-correctly with DECERR: drains the full write burst, then returns one B; returns ARLEN+1 R beats with a fixed pattern.
- Keeps a saturating error count and the last offending address, for debug.

Parameters:
IdWidth, 5, AXI ID width on the slave side of the crossbar (4 + clog2(2 masters)).
AddrWidth, 64, AXI address width.
DataWidth, 64, AXI data width.
CntWidth, 32, width of the error counter.
ErrData, 64'hDEAD_BEEF_BADC_AB1E, returned read data.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
aw_valid_i/aw_ready_o  in/out  1/1  AW handshake
aw_id_i  in  IdWidth  write ID
aw_addr_i  in  AddrWidth  write address
w_valid_i/w_ready_o  in/out  1/1  W handshake
w_last_i  in  1  last write beat (w_data/w_strb not connected)
b_valid_o/b_ready_i  out/in  1/1  B handshake
b_id_o  out  IdWidth  echoed AW ID
b_resp_o  out  2  always 2'b11
ar_valid_i/ar_ready_o  in/out  1/1  AR handshake
ar_id_i  in  IdWidth  read ID
ar_addr_i  in  AddrWidth  read address
ar_len_i  in  8  burst length minus 1
r_valid_o/r_ready_i  out/in  1/1  R handshake
r_id_o  out  IdWidth  echoed AR ID
r_data_o  out  DataWidth  ErrData
r_resp_o  out  2  always 2'b11
r_last_o  out  1  final beat
err_count_o  out  CntWidth  saturating count of accepted AW+AR
err_addr_o  out  AddrWidth  address of the most recent accepted erroneous request
err_pulse_o  out  1  one-cycle pulse per cycle with an acceptance

Behaviour:
- Reset (rst_ni low, async):
  - Both FSMs go to IDLE; counters clear.
  - aw_ready_o=1, ar_ready_o=1.
  - w_ready_o, b_valid_o, r_valid_o, r_last_o, err_pulse_o = 0.
  - b_id_o, r_id_o = 0; err_count_o=0; err_addr_o=0.
  - Reset mid-burst abandons the transaction silently; no B or R is issued after reset.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: aw_ready_o=1, w_ready_o=0. On AW handshake, latch aw_id, go to W_DATA. W beats arriving before AW stall, because w_ready is 0.
  - W_DATA: aw_ready_o=0, w_ready_o=1. Each W handshake consumes a beat. A handshake with w_last_i=1 moves to W_RESP next cycle.
  - W_RESP: b_valid_o=1, b_id_o=latched ID, b_resp_o=2'b11. b_valid holds until b_ready_i, then go to W_IDLE; the next AW can be accepted the cycle after.
  - One outstanding write at a time. Minimum latency from AW to B_valid is 2 cycles.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: ar_ready_o=1. On AR handshake, latch ar_id and ar_len, clear the 8-bit beat counter, go to R_DATA.
  - R_DATA: ar_ready_o=0, r_valid_o=1, r_data_o=ErrData, r_resp_o=2'b11.
  - r_last_o=1 exactly when beat counter == latched len.
  - The beat counter increments on each R handshake. The handshake with r_last goes to R_IDLE.
  - r_valid never drops while in R_DATA, regardless of r_ready_i.
  - len=255 gives 256 beats; the counter does not wrap before last.
- Read and write channels are fully independent and may be active simultaneously.
- Error log:
  - err_count_o adds (AW hs + AR hs) per cycle, so it increments by 0, 1 or 2.
  - It saturates at 2^CntWidth-1 and never wraps.
  - err_addr_o updates on acceptance. On a simultaneous AW+AR the AW address wins.
  - err_pulse_o is registered: high the cycle after any acceptance.

Decomposition:
- The ariane_soc package gains:
  - localparam logic [1:0] AxiRespDecErr = 2'b11.
  - localparam logic [63:0] DecErrData.
  - typedef enums err_wr_state_t {W_IDLE,W_DATA,W_RESP} and err_rd_state_t {R_IDLE,R_DATA}.
- One sub-module, axi_decerr_rd_ch, holds the read FSM and beat counter. The write FSM and error log stay in the top.

Test Plan:
- AW id=5 addr=0x5000_0000 len=3, 4 W beats (last on the 4th) -> w_ready for exactly 4 beats, then b_valid with b_id=5 and b_resp=11. err_count=1, err_addr=0x5000_0000.
- AR id=3 len=0, r_ready=1 -> a single beat with r_last=1, r_data=ErrData, r_resp=11, r_id=3. ar_ready returns the next cycle.
- AR len=255 with r_ready toggled 1/0 every cycle -> exactly 256 beats; r_last only on beat 256; r_valid stays high throughout.
- Same-cycle AW addr=0xA and AR addr=0xB -> err_count += 2, err_addr=0xA, err_pulse high for one cycle. B and R complete independently.
- rst_ni asserted low during W_DATA and R_DATA (beat 2 of len=7) -> outputs return to reset values immediately. No stray B/R after reset is released. The next transaction completes normally.
- CntWidth=2, 5 AR requests -> err_count reads 1, 2, 3, 3, 3.
